// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_fifo : parametrised UART receiver (majority vote) with show-ahead   |
// |                FIFO, per-word parity/frame flags and sticky overrun         |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
   parameter int FCLK       = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int DATA_W     = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk50m,
   input  logic                          rst_n,
   input  logic                          rx,
   output logic [DATA_W-1:0]             rx_data,
   output logic                          rx_parity_err,
   output logic                          rx_frame_err,
   output logic                          rx_valid,
   input  logic                          rx_accept,
   output logic                          rx_overrun,
   input  logic                          clr_overrun,
   output logic                          rx_idle,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int c_DIV_RAW = FCLK / BAUD;
   localparam int c_DIV     = (c_DIV_RAW < 8) ? 8 : c_DIV_RAW;
   localparam int c_BCW     = $clog2(c_DIV);
   localparam int c_AW      = $clog2(FIFO_DEPTH);
   localparam int c_WW      = DATA_W + 2;

   localparam logic [c_BCW-1:0] c_BC_ONE  = c_BCW'(1);
   localparam logic [c_BCW-1:0] c_BC_LAST = c_BCW'(c_DIV - 1);
   localparam logic [c_BCW-1:0] c_BC_S0   = c_BCW'(c_DIV / 2 - 1);
   localparam logic [c_BCW-1:0] c_BC_S1   = c_BCW'(c_DIV / 2);
   localparam logic [c_BCW-1:0] c_BC_VOTE = c_BCW'(c_DIV / 2 + 1);
   localparam logic [c_AW-1:0]  c_PTR_ONE = c_AW'(1);
   localparam logic [c_AW:0]    c_CNT_ONE = (c_AW + 1)'(1);
   localparam logic [c_AW:0]    c_FULL    = (c_AW + 1)'(FIFO_DEPTH);
   localparam logic [3:0]       c_NDATA   = 4'(DATA_W);
   localparam logic [3:0]       c_NSTOP   = 4'(STOP_BITS - 1);
   localparam logic             c_ODD     = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

   state_t            r_state;
   logic              r_sync1, r_sync2;
   logic              r_smp0, r_smp1;
   logic [c_BCW-1:0]  r_bc;
   logic [3:0]        r_nbit;
   logic [DATA_W-1:0] r_shift;
   logic              r_perr, r_ferr;

   logic              w_rxs, w_vote, w_at_vote, w_bit_end;
   logic              w_push, w_ferr_new;
   logic [c_WW-1:0]   w_push_word;

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs     = r_sync2;
   assign w_at_vote = (r_bc == c_BC_VOTE);
   assign w_bit_end = (r_bc == c_BC_LAST);
   // Third sample is the live synchronised line at the vote point.
   assign w_vote    = (r_smp0 & r_smp1) | (r_smp0 & w_rxs) | (r_smp1 & w_rxs);

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         r_smp0 <= 1'b1;
         r_smp1 <= 1'b1;
      end else begin
         if (r_bc == c_BC_S0) r_smp0 <= w_rxs;
         if (r_bc == c_BC_S1) r_smp1 <= w_rxs;
      end
   end

   assign w_ferr_new  = r_ferr | ~w_vote;
   assign w_push      = (r_state == S_STOP) && w_at_vote && (r_nbit == c_NSTOP);
   assign w_push_word = {w_ferr_new, r_perr, r_shift};

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_bc    <= '0;
         r_nbit  <= '0;
         r_shift <= '0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_bc <= w_bit_end ? '0 : r_bc + c_BC_ONE;
         case (r_state)
            S_IDLE: begin
               r_bc <= '0;
               if (!w_rxs) begin
                  r_state <= S_START;
                  r_nbit  <= '0;
                  r_perr  <= 1'b0;
                  r_ferr  <= 1'b0;
               end
            end
            S_START: begin
               if (w_at_vote && w_vote)
                  r_state <= S_IDLE;
               else if (w_bit_end)
                  r_state <= S_DATA;
            end
            S_DATA: begin
               if (w_at_vote) begin
                  r_shift <= {w_vote, r_shift[DATA_W-1:1]};
                  r_nbit  <= r_nbit + 4'd1;
               end
               if (w_bit_end && (r_nbit == c_NDATA)) begin
                  r_nbit  <= '0;
                  r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (w_at_vote) r_perr <= (^r_shift) ^ w_vote ^ c_ODD;
               if (w_bit_end) r_state <= S_STOP;
            end
            S_STOP: begin
               if (w_at_vote) begin
                  r_ferr <= w_ferr_new;
                  // Leaving at mid-bit lets a following start bit arrive early.
                  if (r_nbit == c_NSTOP)
                     r_state <= (!w_ferr_new || w_rxs) ? S_IDLE : S_WAIT_HIGH;
                  else
                     r_nbit <= r_nbit + 4'd1;
               end
            end
            S_WAIT_HIGH: begin
               r_bc <= '0;
               if (w_rxs) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_idle = (r_state == S_IDLE);

   logic [c_WW-1:0] r_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_wptr, r_rptr;
   logic [c_AW:0]   r_count;
   logic            r_ovr;
   logic            w_full, w_valid, w_pop, w_wr;
   logic [c_WW-1:0] w_head;

   assign w_full  = (r_count == c_FULL);
   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid & rx_accept;
   assign w_wr    = w_push & (~w_full | w_pop);

   always_ff @(posedge clk50m) begin
      if (w_wr) r_mem[r_wptr] <= w_push_word;
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovr   <= 1'b0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + c_PTR_ONE;
         if (w_pop) r_rptr <= r_rptr + c_PTR_ONE;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_push && w_full && !w_pop)
            r_ovr <= 1'b1;
         else if (clr_overrun)
            r_ovr <= 1'b0;
      end
   end

   assign w_head        = w_valid ? r_mem[r_rptr] : '0;
   assign rx_data       = w_head[DATA_W-1:0];
   assign rx_parity_err = w_head[DATA_W];
   assign rx_frame_err  = w_head[DATA_W+1];
   assign rx_valid      = w_valid;
   assign rx_overrun    = r_ovr;
   assign fifo_count    = r_count;

endmodule
`default_nettype wire
